// File: rtl/store_block.sv
// store_block: streams a size*size result image to CNN memory via a DMA write handshake.
// Optional macro STORE_RELU_EN clamps negative pixels to zero on the write data path.
module store_block (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic        [15:0] size,
    input  logic        [15:0] address,
    input  logic signed [15:0] img [0:1023],
    input  logic               dmaDone,
    output logic        [15:0] dmaAddr,
    output logic        [15:0] dmaIn,
    output logic               writeEnable,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, SETUP, WRITE, DONE} state_e;

    state_e      state_q;
    logic [15:0] base_q;
    logic [10:0] count_q;
    logic [9:0]  index_q;
    logic [15:0] addr_q;
    logic [15:0] data_q;
    logic        we_q;
    logic        done_q;

    logic [10:0] count_d;
    logic [9:0]  index_d;
    logic        last_d;

    function automatic logic [15:0] proc_pixel(input logic signed [15:0] px);
`ifdef STORE_RELU_EN
        return px[15] ? 16'd0 : px;
`else
        return px;
`endif
    endfunction

    // Anything above 32x32 is clamped to the full 1024-pixel buffer.
    always_comb begin
        count_d = (size > 16'd32) ? 11'd1024
                                  : ({5'd0, size[5:0]} * {5'd0, size[5:0]});
        index_d = index_q + 10'd1;
        last_d  = ({1'b0, index_q} == (count_q - 11'd1));
    end

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // the outputs are registered and only updated on the edges that change them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            count_q <= '0;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    we_q   <= 1'b0;
                    done_q <= 1'b0;
                    if (enable) state_q <= SETUP;
                end
                SETUP: begin
                    base_q  <= address;
                    count_q <= count_d;
                    index_q <= '0;
                    if (!enable) begin
                        state_q <= IDLE;
                    end else if (count_d == 11'd0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        // Present the first word on the same edge that enters WRITE.
                        state_q <= WRITE;
                        we_q    <= 1'b1;
                        addr_q  <= address;
                        data_q  <= proc_pixel(img[0]);
                    end
                end
                WRITE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        we_q    <= 1'b0;
                    end else if (dmaDone) begin
                        if (last_d) begin
                            state_q <= DONE;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            index_q <= index_d;
                            addr_q  <= base_q + {6'd0, index_d};
                            data_q  <= proc_pixel(img[index_d]);
                        end
                    end
                end
                DONE: begin
                    if (!enable) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dmaAddr     = addr_q;
    assign dmaIn       = data_q;
    assign writeEnable = we_q;
    assign done        = done_q;

endmodule

// File: doc/store_block.md
STORE_BLOCK -- requirements
Module: store_block

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have: enable  in  1  start request, held high for the whole transfer.
REQ-004 SHALL have: size  in  16  output image side length in pixels; transfer count is size*size.
REQ-005 SHALL have: address  in  16  base memory address of the output image.
REQ-006 SHALL have: img  in  signed 16 x [0:1023]  result pixels, row-major, stable while enable is high.
REQ-007 SHALL have: dmaDone  in  1  memory accepted the current write this cycle.
REQ-008 SHALL have: dmaAddr  out  16  write address to CNN memory.
REQ-009 SHALL have: dmaIn  out  16  write data to CNN memory.
REQ-010 SHALL have: writeEnable  out  1  write request qualifier.
REQ-011 SHALL have: done  out  1  transfer complete.

Function
REQ-012 SHALL implement FSM states IDLE, SETUP, WRITE, DONE.
REQ-013 IDLE: with enable=1, SHALL go to SETUP next edge; otherwise stay IDLE.
REQ-014 SETUP: SHALL latch address into base register, compute count=size*size, and clear index.
REQ-015 SETUP: SHALL saturate count to 1024 when size>32.
REQ-016 SETUP: when count=0, SHALL go directly to DONE; otherwise go to WRITE.
REQ-017 WRITE: SHALL drive writeEnable=1, dmaAddr=(base+index) mod 2^16, dmaIn=processed img[index] (REQ-027).
REQ-018 WRITE: index SHALL advance only on cycles with dmaDone=1; with dmaDone=0, outputs SHALL hold unchanged.
REQ-019 WRITE: when dmaDone=1 and index=count-1, SHALL go to DONE; exactly count writes are accepted per transfer.
REQ-020 DONE: SHALL drive done=1 and writeEnable=0; SHALL hold DONE while enable=1.
REQ-021 DONE: SHALL return to IDLE on enable=0; done falls in the same cycle as the IDLE entry.
REQ-022 Minimum latency, enable rise to done=1: count+2 cycles with dmaDone tied high.
REQ-023 enable dropping during SETUP or WRITE SHALL abort to IDLE next edge; writeEnable=0 and done=0 in IDLE; no partial done.
REQ-024 In IDLE, SETUP and DONE, writeEnable SHALL be 0 and dmaIn/dmaAddr SHALL hold their last values.
REQ-025 Changes to size/address after SETUP SHALL have no effect until the next transfer.

Reset
REQ-026 On reset=1 at a clock edge: state=IDLE, index=0, base=0, count=0, dmaAddr=0, dmaIn=0, writeEnable=0, done=0; reset overrides all other inputs, including mid-transfer.

Configuration
REQ-027 With macro STORE_RELU_EN defined, dmaIn SHALL be 0 for negative pixels and the pixel value otherwise.
REQ-028 Without STORE_RELU_EN, dmaIn SHALL equal img[index] unmodified; all other behaviour is identical.

Verification
REQ-029 size=3, address=100, dmaDone=1, img[i]=i+1 -> 9 writes, addr 100..108, data 1..9, done=1 on cycle 11 after enable.
REQ-030 size=2, dmaDone toggling 1,0,1,0 -> each address/data held during dmaDone=0, exactly 4 accepted writes, done after final accept.
REQ-031 size=0 -> no writeEnable pulse, done=1 two cycles after enable; enable low -> done=0, state IDLE.
REQ-032 size=4, address=16'hFFFE -> addresses FFFE, FFFF, 0000 ... 000D (wrap-around).
REQ-033 img[0]=-5, img[1]=7, size=1..2: with STORE_RELU_EN -> data 0, 7; without -> data 16'hFFFB, 7.
REQ-034 reset asserted at third write of size=3 -> next cycle writeEnable=0, done=0, dmaAddr=0; re-enable restarts at address base+0.
